clk_period_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous square-wave input (for example the output of the lab's divide-by-N clock generators) in units of the system clock `clk`. It is the receive end of the divided-clock path: a divider produces a slow clock, and this block recovers its period and duty from the edges. Results are published with a one-cycle valid strobe. The block also flags loss of signal when no rising edge arrives within the counter range.

---
 rtl/clk_period_meter.sv | 116 +++++++++++
 tb/tb_clk_period_meter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter
//
// Measures the period and high time of a slow square wave that is
// asynchronous to clk, in clk cycles. Rising edges of the synchronized input
// start and end each measurement. A timeout flags loss of signal when no
// rising edge arrives before the period counter reaches its maximum.
//
// Ports:
//   clk        system clock; all logic on its rising edge
//   reset      asynchronous, active-low reset
//   sig_in     measured signal (asynchronous to clk)
//   period     last measured rise-to-rise distance, in clk cycles
//   high_time  clk cycles the input was high during that period
//   meas_valid one-cycle strobe when period/high_time update
//   no_signal  set on timeout, cleared by the next valid measurement
//   state_dbg  current FSM state (0 = IDLE, 1 = MEASURE)
//
// Handshake: meas_valid is a pure strobe with no ready/backpressure. A
// consumer must capture period/high_time in the cycle meas_valid is high, or
// at any time before the next strobe, since both stay stable until then.
module clk_period_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             no_signal,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;

  // s3 lags s2 by one cycle, so the edge detector adds the same fixed delay
  // to every rise and the rise-to-rise distance is reported exactly.
  assign rise      = s2 & ~s3;
  assign state_dbg = (state == MEASURE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      cnt        <= '0;
      hcnt       <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      s1         <= sig_in;
      s2         <= s1;
      s3         <= s2;
      meas_valid <= 1'b0;

      case (state)
        IDLE: begin
          // The first rise only arms the block; there is no earlier rise to
          // measure from.
          if (rise) begin
            state <= MEASURE;
            cnt   <= CNT_ONE;
            hcnt  <= CNT_ONE;
          end
        end

        MEASURE: begin
          if (rise) begin
            // A rise takes priority over a timeout in the same cycle, so a
            // period of exactly CNT_MAX is still reported.
            period     <= cnt;
            high_time  <= hcnt;
            meas_valid <= 1'b1;
            no_signal  <= 1'b0;
            cnt        <= CNT_ONE;
            hcnt       <= CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            // Timeout before the counter could wrap. hcnt never exceeds cnt,
            // so it cannot wrap either. The last results are kept.
            state     <= IDLE;
            no_signal <= 1'b1;
            cnt       <= '0;
            hcnt      <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (s2) begin
              hcnt <= hcnt + CNT_ONE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter. Two instances (CNT_W = 16 and CNT_W = 6)
// see the same clock, reset and input. A reference model works on the
// history of input samples: it finds rising edges by sample index, derives
// period and high time from index differences and sample sums, and applies
// the timeout by distance from the last rise.
module tb_clk_period_meter;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic sig_in = 1'b0;

  logic [15:0] p16;
  logic [15:0] h16;
  logic        v16;
  logic        n16;
  logic        st16;
  logic [5:0]  p6;
  logic [5:0]  h6;
  logic        v6;
  logic        n6;
  logic        st6;

  int checks = 0;
  int errors = 0;

  clk_period_meter #(.CNT_W(16)) dut16 (
    .clk(clk), .reset(reset), .sig_in(sig_in),
    .period(p16), .high_time(h16), .meas_valid(v16),
    .no_signal(n16), .state_dbg(st16)
  );

  clk_period_meter #(.CNT_W(6)) dut6 (
    .clk(clk), .reset(reset), .sig_in(sig_in),
    .period(p6), .high_time(h6), .meas_valid(v6),
    .no_signal(n6), .state_dbg(st6)
  );

  // clock / reset
  always #5 clk = ~clk;

  // observed outputs gathered per instance (index 0: CNT_W=16, 1: CNT_W=6)
  logic [15:0] obs_p[2];
  logic [15:0] obs_h[2];
  logic        obs_v[2];
  logic        obs_n[2];
  logic        obs_st[2];

  always_comb begin
    obs_p[0]  = p16;
    obs_p[1]  = {10'd0, p6};
    obs_h[0]  = h16;
    obs_h[1]  = {10'd0, h6};
    obs_v[0]  = v16;
    obs_v[1]  = v6;
    obs_n[0]  = n16;
    obs_n[1]  = n6;
    obs_st[0] = st16;
    obs_st[1] = st6;
  end

  // reference model
  int          max_cnt[2] = '{65535, 63};
  bit          samp[$];
  bit          armed[2];
  int          last_rise[2];
  logic [15:0] exp_p[2];
  logic [15:0] exp_h[2];
  logic        exp_v[2];
  logic        exp_n[2];
  logic        exp_st[2];
  int          m_j;
  int          m_hsum;
  bit          m_rise;

  function automatic bit smp(input int i);
    if (i < 0 || i >= samp.size()) return 1'b0;
    return samp[i];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp.delete();
      for (int d = 0; d < 2; d++) begin
        armed[d]     = 1'b0;
        last_rise[d] = 0;
        exp_p[d]     = '0;
        exp_h[d]     = '0;
        exp_v[d]     = 1'b0;
        exp_n[d]     = 1'b0;
        exp_st[d]    = 1'b0;
      end
    end else begin
      samp.push_back(sig_in);
      // a sample taken at edge k is acted on at edge k+2
      m_j    = samp.size() - 3;
      m_rise = smp(m_j) && !smp(m_j - 1);
      for (int d = 0; d < 2; d++) begin
        exp_v[d] = 1'b0;
        if (armed[d]) begin
          if (m_rise) begin
            m_hsum = 0;
            for (int i = last_rise[d]; i < m_j; i++) m_hsum += int'(smp(i));
            exp_p[d]     = 16'(m_j - last_rise[d]);
            exp_h[d]     = 16'(m_hsum);
            exp_v[d]     = 1'b1;
            exp_n[d]     = 1'b0;
            last_rise[d] = m_j;
          end else if (m_j - last_rise[d] == max_cnt[d]) begin
            armed[d] = 1'b0;
            exp_n[d] = 1'b1;
          end
        end else if (m_rise) begin
          armed[d]     = 1'b1;
          last_rise[d] = m_j;
        end
        exp_st[d] = armed[d];
      end
    end
  end

  task automatic test_reset();
    reset  = 1'b0;
    sig_in = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d]} !== 35'd0) begin
          errors++;
          $display("FAIL reset dut%0d: v/ns/st/period/high got %b/%b/%b/%0d/%0d want all 0",
                   d, obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d]);
        end
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_div10();
    int prev_v = -1;
    int nv = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d]} !==
            {exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]}) begin
          errors++;
          $display("FAIL div10 dut%0d c=%0d: v/ns/st/period/high got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                   d, c, obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d],
                   exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]);
        end
      end
      if (v16) begin
        nv++;
        checks++;
        if (p16 !== 16'd10 || h16 !== 16'd5 || n16 !== 1'b0 || (prev_v >= 0 && c - prev_v != 10)) begin
          errors++;
          $display("FAIL div10_pulse c=%0d: period/high/ns/spacing got %0d/%0d/%b/%0d want 10/5/0/10",
                   c, p16, h16, n16, c - prev_v);
        end
        prev_v = c;
      end
      sig_in = (c % 10) < 5;
    end
    checks++;
    if (nv != 11) begin
      errors++;
      $display("FAIL div10_count: pulses got %0d want 11", nv);
    end
  endtask

  task automatic test_asym();
    int rc;
    for (int c = 0; c < 75; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d]} !==
            {exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]}) begin
          errors++;
          $display("FAIL asym dut%0d c=%0d: v/ns/st/period/high got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                   d, c, obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d],
                   exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]);
        end
      end
      if (v16) begin
        rc = c - 3;
        if (rc >= 7 && rc <= 35) begin
          checks++;
          if (p16 !== 16'd7 || h16 !== 16'd3) begin
            errors++;
            $display("FAIL asym_3_4 c=%0d: period/high got %0d/%0d want 7/3", c, p16, h16);
          end
        end else if (rc >= 43) begin
          checks++;
          if (p16 !== 16'd8 || h16 !== 16'd6) begin
            errors++;
            $display("FAIL asym_6_2 c=%0d: period/high got %0d/%0d want 8/6", c, p16, h16);
          end
        end
      end
      sig_in = (c < 35) ? ((c % 7) < 3) : (((c - 35) % 8) < 6);
    end
  endtask

  task automatic test_timeout();
    int last_v = -1;
    int ns_c = -1;
    int first_v = -1;
    int early_clear = 0;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d]} !==
            {exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]}) begin
          errors++;
          $display("FAIL timeout dut%0d c=%0d: v/ns/st/period/high got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                   d, c, obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d],
                   exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]);
        end
      end
      if (v6) last_v = c;
      if (n6 && ns_c < 0) ns_c = c;
      sig_in = (c < 50) && ((c % 10) < 5);
    end
    checks++;
    if (ns_c < 0 || last_v < 0 || ns_c - last_v != 63) begin
      errors++;
      $display("FAIL timeout_delay: cycles from last rise to no_signal got %0d want 63", ns_c - last_v);
    end
    checks++;
    if (p6 !== 6'd10 || st6 !== 1'b0 || n6 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold: period/state/ns got %0d/%b/%b want 10/0/1", p6, st6, n6);
    end
    // restart: first rise re-arms, second rise produces the first pulse
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d]} !==
            {exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]}) begin
          errors++;
          $display("FAIL restart dut%0d c=%0d: v/ns/st/period/high got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                   d, c, obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d],
                   exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]);
        end
      end
      if (first_v < 0) begin
        if (v6) begin
          first_v = c;
          checks++;
          if (n6 !== 1'b0 || p6 !== 6'd10) begin
            errors++;
            $display("FAIL restart_pulse: ns/period got %b/%0d want 0/10", n6, p6);
          end
        end else if (!n6) begin
          early_clear++;
        end
      end
      sig_in = (c % 10) < 5;
    end
    checks++;
    if (first_v != 13 || early_clear != 0) begin
      errors++;
      $display("FAIL restart_first: first pulse cycle got %0d want 13, early clears got %0d want 0",
               first_v, early_clear);
    end
  endtask

  task automatic test_held_high();
    int arm_c = -1;
    int ns_c = -1;
    int nv = 0;
    @(negedge clk);
    sig_in = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d]} !==
            {exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]}) begin
          errors++;
          $display("FAIL held_high dut%0d c=%0d: v/ns/st/period/high got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                   d, c, obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d],
                   exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]);
        end
      end
      if (st6 && arm_c < 0) arm_c = c;
      if (n6 && ns_c < 0) ns_c = c;
      if (v6) nv++;
      sig_in = 1'b1;
    end
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL held_high_pulses: pulses got %0d want 0", nv);
    end
    checks++;
    if (arm_c < 0 || ns_c < 0 || ns_c - arm_c != 63) begin
      errors++;
      $display("FAIL held_high_timeout: cycles from rise to no_signal got %0d want 63", ns_c - arm_c);
    end
  endtask

  task automatic test_reset_mid();
    int first_v = -1;
    logic [15:0] first_p = '0;
    logic [15:0] first_h = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d]} !==
            {exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]}) begin
          errors++;
          $display("FAIL reset_mid dut%0d c=%0d: v/ns/st/period/high got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                   d, c, obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d],
                   exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]);
        end
      end
      if (c > 26 && v16 && first_v < 0) begin
        first_v = c;
        first_p = p16;
        first_h = h16;
      end
      sig_in = (c % 10) < 5;
      if (c == 26) begin
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
          checks++;
          if ({obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d]} !== 35'd0) begin
            errors++;
            $display("FAIL reset_async dut%0d: v/ns/st/period/high got %b/%b/%b/%0d/%0d want all 0",
                     d, obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d]);
          end
        end
        #9 reset = 1'b1;
      end
    end
    checks++;
    if (first_v != 43 || first_p !== 16'd10 || first_h !== 16'd5) begin
      errors++;
      $display("FAIL reset_first_pulse: cycle/period/high got %0d/%0d/%0d want 43/10/5",
               first_v, first_p, first_h);
    end
  endtask

  task automatic test_period2();
    int rc;
    int prev_v = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d]} !==
            {exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]}) begin
          errors++;
          $display("FAIL period2 dut%0d c=%0d: v/ns/st/period/high got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                   d, c, obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d],
                   exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]);
        end
      end
      if (v16) begin
        rc = c - 3;
        if (rc >= 2) begin
          checks++;
          if (p16 !== 16'd2 || h16 !== 16'd1 || (prev_v >= 0 && c - prev_v != 2)) begin
            errors++;
            $display("FAIL period2_pulse c=%0d: period/high/spacing got %0d/%0d/%0d want 2/1/2",
                     c, p16, h16, c - prev_v);
          end
        end
        prev_v = c;
      end
      sig_in = (c % 2) == 0;
    end
  endtask

  task automatic test_random();
    int h;
    int l;
    for (int seg = 0; seg < 8; seg++) begin
      h = int'($urandom_range(1, 8));
      l = int'($urandom_range(1, 8));
      for (int c = 0; c < 4 * (h + l); c++) begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          checks++;
          if ({obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d]} !==
              {exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]}) begin
            errors++;
            $display("FAIL random dut%0d h=%0d l=%0d c=%0d: v/ns/st/period/high got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                     d, h, l, c, obs_v[d], obs_n[d], obs_st[d], obs_p[d], obs_h[d],
                     exp_v[d], exp_n[d], exp_st[d], exp_p[d], exp_h[d]);
          end
        end
        sig_in = (c % (h + l)) < h;
      end
    end
  endtask

  initial begin
    test_reset();
    test_div10();
    test_asym();
    test_timeout();
    test_held_high();
    test_reset_mid();
    test_period2();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
